// File: rtl/sh7034_ibus_arb.sv
// Two-master (CPU / DMAC) internal-bus arbiter in front of the bus state controller.
// Grants ownership, forwards the owner's request and stalls the other master.
module sh7034_ibus_arb #(
  parameter bit DMA_PRIO = 1'b1,
  parameter bit RR       = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [27:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [3:0]  CPU_BA,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  input  logic        CPU_LOCK,
  output logic [31:0] CPU_DO,
  output logic        CPU_BUSY,
  output logic        CPU_GNT,
  input  logic [27:0] DMA_A,
  input  logic [31:0] DMA_DI,
  input  logic [3:0]  DMA_BA,
  input  logic        DMA_WE,
  input  logic        DMA_REQ,
  input  logic        DMA_LOCK,
  output logic [31:0] DMA_DO,
  output logic        DMA_BUSY,
  output logic        DMA_GNT,
  output logic [27:0] S_A,
  output logic [31:0] S_DO,
  output logic [3:0]  S_BA,
  output logic        S_WE,
  output logic        S_REQ,
  output logic        S_LOCK,
  input  logic [31:0] S_DI,
  input  logic        S_BUSY,
  input  logic        S_ACT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_DMA = 2'd2
  } state_t;

  state_t r_state;
  logic   r_started;
  logic   r_last;

  logic w_own_cpu;
  logic w_own_dma;
  logic w_owner_req;
  logic w_owner_lock;
  logic w_other_req;
  logic w_done;
  logic w_release;
  logic w_tie_dma;
  logic w_pick_dma;

  assign w_own_cpu    = (r_state == ST_OWN_CPU);
  assign w_own_dma    = (r_state == ST_OWN_DMA);
  assign w_owner_req  = (w_own_cpu & CPU_REQ)  | (w_own_dma & DMA_REQ);
  assign w_owner_lock = (w_own_cpu & CPU_LOCK) | (w_own_dma & DMA_LOCK);
  assign w_other_req  = (w_own_cpu & DMA_REQ)  | (w_own_dma & CPU_REQ);

  // A transfer is complete once the BSC has shown busy and dropped it, or at once for register accesses.
  assign w_done    = w_owner_req & ~S_BUSY & (r_started | S_ACT);
  assign w_release = (w_done & ~w_owner_lock) | ~w_owner_req;

  assign w_tie_dma  = RR ? ~r_last : DMA_PRIO;
  assign w_pick_dma = DMA_REQ & (~CPU_REQ | w_tie_dma);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_started <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      if (CE_R) begin
        case (r_state)
          ST_IDLE: begin
            if (CPU_REQ | DMA_REQ) begin
              r_state <= w_pick_dma ? ST_OWN_DMA : ST_OWN_CPU;
              r_last  <= w_pick_dma;
            end
          end
          ST_OWN_CPU, ST_OWN_DMA: begin
            // Handover goes straight to the other master; no idle cycle in between.
            if (w_release) begin
              if (w_other_req) begin
                r_state <= w_own_cpu ? ST_OWN_DMA : ST_OWN_CPU;
                r_last  <= w_own_cpu;
              end else if (!w_owner_req) begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (CE_R && (w_done || w_release || (r_state == ST_IDLE)))
        r_started <= 1'b0;
      else if (CE_F && (w_own_cpu || w_own_dma) && S_BUSY)
        r_started <= 1'b1;
    end
  end

  always_comb begin
    S_A    = '0;
    S_DO   = '0;
    S_BA   = '0;
    S_WE   = 1'b0;
    S_REQ  = 1'b0;
    S_LOCK = 1'b0;
    if (w_own_cpu) begin
      S_A    = CPU_A;
      S_DO   = CPU_DI;
      S_BA   = CPU_BA;
      S_WE   = CPU_WE;
      S_REQ  = CPU_REQ;
      S_LOCK = CPU_LOCK;
    end else if (w_own_dma) begin
      S_A    = DMA_A;
      S_DO   = DMA_DI;
      S_BA   = DMA_BA;
      S_WE   = DMA_WE;
      S_REQ  = DMA_REQ;
      S_LOCK = DMA_LOCK;
    end
  end

  assign CPU_GNT  = w_own_cpu;
  assign DMA_GNT  = w_own_dma;
  assign CPU_BUSY = w_own_cpu ? ~w_done : CPU_REQ;
  assign DMA_BUSY = w_own_dma ? ~w_done : DMA_REQ;
  assign CPU_DO   = S_DI;
  assign DMA_DO   = S_DI;

endmodule
